// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer built around one full-adder cell.
// Adds two WIDTH-bit operands LSB first, one bit per clock, then pulses done.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (A-B via ~B and carry-in 1).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              fa_s;
    logic              fa_co;
    logic              last_bit;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

    // Operand/carry values captured on an accepted start.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
`else
        b_load     = b;
        carry_load = cin;
`endif
    end

    // Next-state, datapath shift and full-adder cell.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
        fa_co    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit = (cnt_q == CntW'(WIDTH - 1));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (last_bit) begin
                    cout_d  = fa_co;
                    state_d = StDone;
                end else begin
                    // Counter stops at WIDTH-1 so it cannot wrap mid-operation.
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // start is only honoured outside RUN.
        if (start && (state_q != StRun)) begin
            a_d     = a;
            b_d     = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from flops.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH = 8, 4 and 32.
// Optional feature macro: SERIAL_ADDER_SUB_EN enables the subtract checks.
module tb_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        cin_r;
    logic        sub_r;
    logic        start8, start4, start32;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy4, done4, cout4;
    logic [3:0]  sum4;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int          cur_w;
    logic        o_busy, o_done, o_cout;
    logic [31:0] o_sum;

    int n_cmp;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a_r[7:0]),
        .b     (b_r[7:0]),
        .cin   (cin_r),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a_r[3:0]),
        .b     (b_r[3:0]),
        .cin   (cin_r),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start32),
        .a     (a_r),
        .b     (b_r),
        .cin   (cin_r),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy32),
        .done  (done32),
        .sum   (sum32),
        .cout  (cout32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck DUT can never hang the run.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Observe the DUT currently under test.
    always_comb begin
        o_busy = busy8;
        o_done = done8;
        o_cout = cout8;
        o_sum  = {24'd0, sum8};
        case (cur_w)
            4: begin
                o_busy = busy4;
                o_done = done4;
                o_cout = cout4;
                o_sum  = {28'd0, sum4};
            end
            32: begin
                o_busy = busy32;
                o_done = done32;
                o_cout = cout32;
                o_sum  = sum32;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        start8  = (cur_w == 8)  ? v : 1'b0;
        start4  = (cur_w == 4)  ? v : 1'b0;
        start32 = (cur_w == 32) ? v : 1'b0;
    endtask

    // Reference: plain unsigned arithmetic on the masked operands.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s,
                         output logic [31:0] e_sum, output logic e_cout);
        longint unsigned mask;
        longint unsigned am, bm, tot;
        mask = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = longint'(a) & mask;
        bm   = longint'(b) & mask;
        if (s) begin
            e_sum  = 32'((am - bm) & mask);
            e_cout = (am >= bm);
        end else begin
            tot    = am + bm + longint'(c);
            e_sum  = 32'(tot & mask);
            e_cout = tot[w];
        end
    endtask

    // One operation with a single-cycle start; optional noise on start/operands during RUN.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input bit noise);
        logic [31:0] e_sum;
        logic        e_cout;
        int          busy_n, lat;
        bit          seen;
        model(w, a, b, c, s, e_sum, e_cout);
        @(negedge clk);
        cur_w = w;
        a_r = a; b_r = b; cin_r = c; sub_r = s;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        busy_n = 0;
        lat    = 1;
        seen   = 0;
        for (int k = 0; k < w + 4 && !seen; k++) begin
            if (o_done) begin
                seen = 1;
                set_start(1'b0);
            end else begin
                if (o_busy) busy_n++;
                if (noise) begin
                    a_r = $urandom; b_r = $urandom; cin_r = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
                    sub_r = 1'($urandom);
`endif
                    set_start(1'($urandom));
                end
                @(negedge clk);
                lat++;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(w + 1));
        check("busy_cycles", 64'(busy_n), 64'(w));
        check("busy_at_done", 64'(o_busy), 64'd0);
        check("sum", 64'(o_sum), 64'(e_sum));
        check("cout", 64'(o_cout), 64'(e_cout));
        @(negedge clk);
        check("done_single", 64'(o_done), 64'd0);
        check("idle_after", 64'(o_busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ba [3];
        logic [31:0] bb [3];
        logic [31:0] es [3];
        logic        ec [3];
        int          lat;
        bit          seen;
        logic        rs;

        n_cmp = 0; n_fail = 0;
        cur_w = 8;
        rst_n = 1'b0;
        a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
        start8 = 1'b0; start4 = 1'b0; start32 = 1'b0;

        // Reset state of all three instances.
        #12;
        check("rst_busy", 64'({busy8, busy4, busy32}), 64'd0);
        check("rst_done", 64'({done8, done4, done32}), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        check("rst_sum32", 64'(sum32), 64'd0);
        check("rst_cout", 64'({cout8, cout4, cout32}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic addition and the carry-out case.
        run_op(8, 32'h35, 32'h4A, 1'b0, 1'b0, 0);
        run_op(8, 32'hFF, 32'h01, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_sum", 64'(o_sum), 64'h01);
            check("hold_cout", 64'(o_cout), 64'd1);
        end

        // Back-to-back with start held high; operands scrambled during RUN.
        ba = '{32'h01, 32'h03, 32'h80};
        bb = '{32'h02, 32'h04, 32'h80};
        for (int i = 0; i < 3; i++) model(8, ba[i], bb[i], 1'b0, 1'b0, es[i], ec[i]);
        cur_w = 8;
        @(negedge clk);
        a_r = ba[0]; b_r = bb[0]; cin_r = 1'b0; sub_r = 1'b0;
        set_start(1'b1);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                lat++;
                if (o_done) seen = 1;
                else begin
                    a_r = $urandom; b_r = $urandom; cin_r = 1'($urandom); sub_r = 1'($urandom);
                end
            end
            check("b2b_seen", 64'(seen), 64'd1);
            check("b2b_period", 64'(lat), 64'd9);
            check("b2b_sum", 64'(o_sum), 64'(es[i]));
            check("b2b_cout", 64'(o_cout), 64'(ec[i]));
            if (i < 2) begin
                a_r = ba[i+1]; b_r = bb[i+1]; cin_r = 1'b0; sub_r = 1'b0;
            end else begin
                set_start(1'b0);
            end
            @(negedge clk);
            check("b2b_done_low", 64'(o_done), 64'd0);
            lat = 1;
        end
        check("b2b_idle", 64'(o_busy), 64'd0);

        // Reset asserted in the 4th RUN cycle discards the partial result.
        cur_w = 8;
        @(negedge clk);
        a_r = 32'hAA; b_r = 32'h55; cin_r = 1'b0; sub_r = 1'b0;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_sum", 64'(o_sum), 64'd0);
        check("midrst_cout", 64'(o_cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8, 32'h10, 32'h20, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8, 32'h50, 32'h20, 1'b0, 1'b1, 0);
        run_op(8, 32'h20, 32'h50, 1'b1, 1'b1, 0);
`endif

        // Random sweeps with noise on the don't-care inputs during RUN.
        for (int i = 0; i < 1000; i++) begin
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            run_op(4, $urandom, $urandom, 1'($urandom), rs, 1);
        end
        for (int i = 0; i < 1000; i++) begin
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            run_op(32, $urandom, $urandom, 1'($urandom), rs, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
